// File: rtl/mac_row_feeder.sv
// mac_row_feeder: drives mac_row's west edge (in_w/inst_w) through
// kernel load, one bubble, activation execute and a col-cycle drain.
module mac_row_feeder #(
    parameter int bw     = 4,
    parameter int col    = 2,
    parameter int cnt_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] n_act,
    input  logic [bw-1:0]     w_data,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [bw-1:0]     a_data,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [bw-1:0]     in_w,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, BUBBLE, EXEC, DRAIN} state_t;

    localparam logic [cnt_bw-1:0] last_col = cnt_bw'(col - 1);

    state_t            state_q, state_d;
    logic [cnt_bw-1:0] n_act_q, n_act_d;
    logic [cnt_bw-1:0] wcnt_q, wcnt_d;
    logic [cnt_bw-1:0] acnt_q, acnt_d;
    logic [cnt_bw-1:0] dcnt_q, dcnt_d;
    logic [bw-1:0]     in_w_q, in_w_d;
    logic [1:0]        inst_w_q, inst_w_d;
    logic              done_q, done_d;
    logic              w_hs, a_hs;

    // Ready is a pure state decode so it never loops back through valid.
    assign w_ready = state_q == LOAD;
    assign a_ready = state_q == EXEC;
    assign w_hs    = w_valid & w_ready;
    assign a_hs    = a_valid & a_ready;
    assign busy    = state_q != IDLE;
    assign in_w    = in_w_q;
    assign inst_w  = inst_w_q;
    assign done    = done_q;

    always_comb begin
        state_d  = state_q;
        n_act_d  = n_act_q;
        wcnt_d   = wcnt_q;
        acnt_d   = acnt_q;
        dcnt_d   = dcnt_q;
        in_w_d   = '0;
        inst_w_d = 2'b00;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_act_d = n_act;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    in_w_d   = w_data;
                    inst_w_d = 2'b01;
                    wcnt_d   = wcnt_q + cnt_bw'(1);
                    state_d  = (wcnt_q == last_col) ? BUBBLE : LOAD;
                end
            end
            BUBBLE: state_d = (n_act_q != '0) ? EXEC : DRAIN;
            EXEC: begin
                if (a_hs) begin
                    in_w_d   = a_data;
                    inst_w_d = 2'b10;
                    acnt_d   = acnt_q + cnt_bw'(1);
                    state_d  = (acnt_q == n_act_q - cnt_bw'(1)) ? DRAIN : EXEC;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + cnt_bw'(1);
                if (dcnt_q == last_col) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            n_act_q  <= '0;
            wcnt_q   <= '0;
            acnt_q   <= '0;
            dcnt_q   <= '0;
            in_w_q   <= '0;
            inst_w_q <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_act_q  <= n_act_d;
            wcnt_q   <= wcnt_d;
            acnt_q   <= acnt_d;
            dcnt_q   <= dcnt_d;
            in_w_q   <= in_w_d;
            inst_w_q <= inst_w_d;
            done_q   <= done_d;
        end
    end
endmodule
